// File: rtl/cnn_conv1_mac_ctrl.sv
// conv1 MAC sequencer: streams KLEN pixel/weight pairs through the shared external
// multiplier, accumulates onto a bias and requantises to a saturated 14-bit result.
module cnn_conv1_mac_ctrl #(
  parameter int unsigned KLEN   = 9,
  parameter int unsigned IMG_AW = 10,
  parameter int unsigned W_AW   = 4,
  parameter int unsigned ACC_W  = 28,
  parameter int unsigned SHIFT  = 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [IMG_AW-1:0] img_base,
  input  logic [ACC_W-1:0]  bias,
  output logic [IMG_AW-1:0] img_address0,
  output logic              img_ce0,
  input  logic [13:0]       img_q0,
  output logic [W_AW-1:0]   w_address0,
  output logic              w_ce0,
  input  logic [8:0]        w_q0,
  output logic [13:0]       mul_din0,
  output logic [8:0]        mul_din1,
  input  logic [23:0]       mul_dout,
  output logic [13:0]       ap_return
);

  // Shared fetch/drain counter; KLEN is at most 15.
  localparam int unsigned KW = 4;

  localparam logic signed [ACC_W-1:0] RetMax = ACC_W'(8191);
  localparam logic signed [ACC_W-1:0] RetMin = ACC_W'(-8192);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e                   state_q, state_d;
  logic [KW-1:0]            cnt_q, cnt_d;
  logic [IMG_AW-1:0]        base_q, base_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     f_vld_q, f_vld_d;
  logic                     l_vld_q, l_vld_d;
  logic                     m_vld_q, m_vld_d;
  logic [13:0]              din0_q, din0_d;
  logic [8:0]               din1_q, din1_d;
  logic [23:0]              prod_q, prod_d;
  logic [13:0]              ret_q, ret_d;
  logic signed [ACC_W-1:0]  prod_ext;

  function automatic logic [13:0] requant(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> SHIFT;
    if (s > RetMax) begin
      return 14'h1fff;
    end else if (s < RetMin) begin
      return 14'h2000;
    end
    return s[13:0];
  endfunction

  assign prod_ext = ACC_W'($signed(prod_q));

  // Operand/product pipeline: no stalls, each stage just follows its valid bit.
  always_comb begin
    l_vld_d = f_vld_q;
    m_vld_d = l_vld_q;
    din0_d  = f_vld_q ? img_q0 : din0_q;
    din1_d  = f_vld_q ? w_q0 : din1_q;
    prod_d  = l_vld_q ? mul_dout : prod_q;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    acc_d        = acc_q;
    ret_d        = ret_q;
    f_vld_d      = 1'b0;
    ap_idle      = 1'b0;
    ap_done      = 1'b0;
    ap_ready     = 1'b0;
    img_ce0      = 1'b0;
    w_ce0        = 1'b0;
    img_address0 = '0;
    w_address0   = '0;

    if (m_vld_q) begin
      acc_d = acc_q + prod_ext;
    end

    unique case (state_q)
      StIdle: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          base_d  = img_base;
          acc_d   = $signed(bias);
          cnt_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        img_ce0      = 1'b1;
        w_ce0        = 1'b1;
        img_address0 = base_q + IMG_AW'(cnt_q);
        w_address0   = W_AW'(cnt_q);
        f_vld_d      = 1'b1;
        if (cnt_q == KW'(KLEN - 1)) begin
          ap_ready = 1'b1;
          cnt_d    = '0;
          state_d  = StDrain;
        end else begin
          cnt_d = cnt_q + KW'(1);
        end
      end
      StDrain: begin
        if (cnt_q == KW'(2)) begin
          // Final product lands on this edge, so requantise the post-add value.
          ret_d   = requant(acc_d);
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + KW'(1);
        end
      end
      StDone: begin
        ap_done = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      base_q  <= '0;
      acc_q   <= '0;
      ret_q   <= '0;
      f_vld_q <= 1'b0;
      l_vld_q <= 1'b0;
      m_vld_q <= 1'b0;
      din0_q  <= '0;
      din1_q  <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      ret_q   <= ret_d;
      f_vld_q <= f_vld_d;
      l_vld_q <= l_vld_d;
      m_vld_q <= m_vld_d;
      din0_q  <= din0_d;
      din1_q  <= din1_d;
      prod_q  <= prod_d;
    end
  end

  assign mul_din0  = din0_q;
  assign mul_din1  = din1_q;
  assign ap_return = ret_q;

endmodule

// File: tb/tb_cnn_conv1_mac_ctrl.sv
// Bench for cnn_conv1_mac_ctrl: BRAM and multiplier models plus an arithmetic
// reference for the requantised dot product.
module tb_cnn_conv1_mac_ctrl;
  localparam int KLEN  = 9;
  localparam int SHIFT = 8;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_done, ap_idle, ap_ready;
  logic [9:0]  img_base;
  logic [27:0] bias;
  logic [9:0]  img_address0;
  logic        img_ce0;
  logic [13:0] img_q0;
  logic [3:0]  w_address0;
  logic        w_ce0;
  logic [8:0]  w_q0;
  logic [13:0] mul_din0;
  logic [8:0]  mul_din1;
  logic [23:0] mul_dout;
  logic [13:0] ap_return;

  int img_mem[1024];
  int w_mem[16];
  int checks = 0;
  int errors = 0;

  cnn_conv1_mac_ctrl dut (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .ap_start     (ap_start),
    .ap_done      (ap_done),
    .ap_idle      (ap_idle),
    .ap_ready     (ap_ready),
    .img_base     (img_base),
    .bias         (bias),
    .img_address0 (img_address0),
    .img_ce0      (img_ce0),
    .img_q0       (img_q0),
    .w_address0   (w_address0),
    .w_ce0        (w_ce0),
    .w_q0         (w_q0),
    .mul_din0     (mul_din0),
    .mul_din1     (mul_din1),
    .mul_dout     (mul_dout),
    .ap_return    (ap_return)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) begin
    if (img_ce0) img_q0 <= 14'(img_mem[img_address0]);
    if (w_ce0) w_q0 <= 9'(w_mem[w_address0]);
  end

  assign mul_dout = {{10{mul_din0[13]}}, mul_din0} * {{15{mul_din1[8]}}, mul_din1};

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint model(input int base, input longint b);
    longint acc, div, q;
    acc = b;
    for (int k = 0; k < KLEN; k++) acc += longint'(img_mem[(base + k) % 1024]) * w_mem[k];
    div = longint'(1) << SHIFT;
    q = acc / div;
    if (acc < 0 && (acc % div) != 0) q = q - 1;
    if (q > 8191) q = 8191;
    if (q < -8192) q = -8192;
    return q;
  endfunction

  task automatic fill(input int px, input int wt);
    for (int i = 0; i < 1024; i++) img_mem[i] = px;
    for (int i = 0; i < 16; i++) w_mem[i] = wt;
  endtask

  task automatic fill_random();
    int mag;
    mag = int'($urandom_range(3, 13));
    for (int i = 0; i < 1024; i++)
      img_mem[i] = int'($urandom_range(0, (1 << mag) - 1)) - (1 << (mag - 1));
    for (int i = 0; i < 16; i++) w_mem[i] = int'($urandom_range(0, 511)) - 256;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_idle"}, longint'(ap_idle), 1);
    chk({tag, "_done"}, longint'(ap_done), 0);
    chk({tag, "_ready"}, longint'(ap_ready), 0);
    chk({tag, "_ce"}, longint'({img_ce0, w_ce0}), 0);
    chk({tag, "_addr"}, longint'({img_address0, w_address0}), 0);
    chk({tag, "_din"}, longint'({mul_din0, mul_din1}), 0);
    chk({tag, "_ret"}, longint'(ap_return), 0);
  endtask

  // One full operation from the accept cycle (cycle 0) through the done cycle.
  task automatic run_op(input int base, input longint b, input bit hold, input bit poke);
    longint exp;
    exp = model(base, b);
    @(negedge ap_clk);
    chk("idle_c0", longint'(ap_idle), 1);
    img_base = 10'(base);
    bias     = 28'(b);
    ap_start = 1'b1;
    for (int c = 1; c <= KLEN + 4; c++) begin
      @(negedge ap_clk);
      if (!hold) ap_start = (poke && c == 3);
      chk("idle", longint'(ap_idle), 0);
      chk("ready", longint'(ap_ready), longint'(c == KLEN));
      chk("done", longint'(ap_done), longint'(c == KLEN + 4));
      chk("ce", longint'({img_ce0, w_ce0}), (c <= KLEN) ? 3 : 0);
      if (c <= KLEN) begin
        chk("img_addr", longint'(img_address0), longint'((base + c - 1) % 1024));
        chk("w_addr", longint'(w_address0), longint'(c - 1));
      end
      if (c >= 3 && c <= KLEN + 2) begin
        chk("din0", longint'($signed(mul_din0)), longint'(img_mem[(base + c - 3) % 1024]));
        chk("din1", longint'($signed(mul_din1)), longint'(w_mem[c - 3]));
      end
      if (c == KLEN + 4) chk("ap_return", longint'($signed(ap_return)), exp);
    end
  endtask

  initial begin
    ap_rst   = 1'b1;
    ap_start = 1'b0;
    img_base = '0;
    bias     = '0;
    fill(0, 0);
    repeat (2) @(negedge ap_clk);
    reset_vals("rst");
    ap_rst = 1'b0;

    // Saturation high, saturation low, floor of a small negative sum.
    fill(8191, 255);
    run_op(0, 0, 1'b0, 1'b0);
    fill(-8192, 255);
    run_op(5, 0, 1'b0, 1'b0);
    fill(0, 0);
    img_mem[100] = -1;
    w_mem[0] = 1;
    run_op(100, 0, 1'b0, 1'b0);
    fill(-1, 1);
    run_op(7, 0, 1'b0, 1'b0);

    // Bias only, then address wrap with pixels 1..9.
    fill(0, 77);
    run_op(300, 256, 1'b0, 1'b0);
    fill(0, 1);
    for (int i = 0; i < KLEN; i++) img_mem[(1020 + i) % 1024] = i + 1;
    run_op(1020, 25600, 1'b0, 1'b0);

    // Start pulse during fetch must be ignored; DUT stays idle afterwards.
    fill_random();
    run_op(int'($urandom_range(0, 1023)), 1000, 1'b0, 1'b1);
    @(negedge ap_clk);
    chk("poke_idle", longint'(ap_idle), 1);
    @(negedge ap_clk);
    chk("poke_noce", longint'(img_ce0), 0);

    // ap_start held high: back-to-back ops every KLEN+5 cycles.
    fill_random();
    run_op(10, -5000, 1'b1, 1'b0);
    run_op(500, 123456, 1'b1, 1'b0);
    run_op(1000, -77, 1'b0, 1'b0);

    // Reset asserted in cycle 5 of a run abandons it.
    fill_random();
    @(negedge ap_clk);
    img_base = 10'd40;
    bias     = 28'd999;
    ap_start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge ap_clk);
      ap_start = 1'b0;
    end
    ap_rst = 1'b1;
    @(negedge ap_clk);
    reset_vals("midrst");
    ap_rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge ap_clk);
      chk("midrst_nodone", longint'(ap_done), 0);
      chk("midrst_idle", longint'(ap_idle), 1);
    end
    run_op(40, 999, 1'b0, 1'b0);

    // Randomized operations.
    for (int n = 0; n < 10; n++) begin
      fill_random();
      run_op(int'($urandom_range(0, 1023)),
             longint'($urandom_range(0, 1 << 22)) - (longint'(1) << 21),
             1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
